// File: rtl/ib_pkg.sv
// Shared types for the decoded-instruction buffer: entry layout, lane count,
// opcode encodings and the controller state enum.
package ib_pkg;

  localparam int IB_LANES = 4;

  // 26-bit decoded entry. Owners are ROB tags of the producing instruction
  // when the matching dep flag says the operand is produced in-flight.
  typedef struct packed {
    logic [5:0] opcode;
    logic       a_dep;
    logic [2:0] a_owner;
    logic       b_dep;
    logic [2:0] b_owner;
    logic [3:0] rt;
    logic [3:0] ra;
    logic [3:0] rb;
  } ib_entry_t;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ALU = 6'h01;
  localparam logic [5:0] OP_LD  = 6'h02;
  localparam logic [5:0] OP_ST  = 6'h03;
  localparam logic [5:0] OP_BR  = 6'h04;
  localparam logic [5:0] OP_JMP = 6'h05;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } ib_state_e;

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/instr_buffer_if.sv
// Fetch/decode + dispatch facing bundle of the instruction buffer.
// slave: the buffer itself; master: the surrounding pipeline (or a bench).
interface instr_buffer_if
  import ib_pkg::*;
#(
  parameter int DEPTH = 16
) ();

  logic                               flush;
  logic [2:0]                         enq_count;
  ib_entry_t [IB_LANES-1:0]           enq_entry;
  logic [2:0]                         fetch_slots;
  logic [IB_LANES-1:0]                deq_valid;
  ib_entry_t [IB_LANES-1:0]           deq_entry;
  logic [2:0]                         deq_accept;
  logic [$clog2(DEPTH):0]             occupancy;
  logic                               overflow_err;

  modport slave (
    input  flush, enq_count, enq_entry, deq_accept,
    output fetch_slots, deq_valid, deq_entry, occupancy, overflow_err
  );

  modport master (
    output flush, enq_count, enq_entry, deq_accept,
    input  fetch_slots, deq_valid, deq_entry, occupancy, overflow_err
  );

endinterface

// File: rtl/ib_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping and the registered fetch credit.
// clr zeroes everything (flush or squash cycle); enq_en is low whenever the
// enqueue lanes must be ignored, which also suppresses overflow detection.
module ib_ptr_ctrl
  import ib_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       enq_en,
  input  logic [2:0]                 enq_count,
  input  logic [2:0]                 deq_accept,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH)-1:0]   tail,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [2:0]                 fetch_slots,
  output logic [2:0]                 enq_n,
  output logic                       overflow_set
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [OW-1:0] LANES_C = OW'(IB_LANES);

  logic [OW-1:0] deq_req;
  logic [OW-1:0] deq_k;
  logic [OW-1:0] occ_d;
  logic [OW-1:0] room;
  logic [2:0]    slots_d;

  // Accepted lanes, retired lanes and the credit derived from the next occupancy.
  always_comb begin
    enq_n        = 3'd0;
    overflow_set = 1'b0;
    deq_req      = OW'(deq_accept);
    deq_k        = '0;
    occ_d        = '0;
    if (enq_en) begin
      enq_n        = min3(enq_count, fetch_slots);
      overflow_set = (enq_count > fetch_slots);
    end
    if (!clr) begin
      deq_k = (deq_req < occupancy) ? deq_req : occupancy;
      occ_d = occupancy + OW'(enq_n) - deq_k;
    end
    room    = DEPTH_C - occ_d;
    slots_d = (room >= LANES_C) ? 3'(IB_LANES) : room[2:0];
  end

  // Pointer, occupancy and credit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      fetch_slots <= 3'(IB_LANES);
    end else if (clr) begin
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      fetch_slots <= slots_d;
    end else begin
      head        <= head + deq_k[PW-1:0];
      tail        <= tail + PW'(enq_n);
      occupancy   <= occ_d;
      fetch_slots <= slots_d;
    end
  end

endmodule

// File: rtl/instr_buffer.sv
// Decoded-instruction queue between decode and dispatch: 4-wide enqueue with
// credit, 4-wide in-order presentation, squash on taken jump.
// Optional build macro IB_PERF_EN adds saturating full-cycle and
// squashed-entry counters.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_RUN    | normal enqueue/dequeue
// ST_SQUASH | one cycle after a flush; decode's wrong-path lanes dropped
module instr_buffer
  import ib_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_buffer_if.slave    ib
`ifdef IB_PERF_EN
  ,
  output logic [31:0]      perf_full_cycles,
  output logic [31:0]      perf_squashed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  ib_state_e       state_q;
  ib_state_e       state_d;
  logic            clr;
  logic            enq_en;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [2:0]      enq_n;
  logic            overflow_set;
  ib_entry_t       mem [DEPTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state and pointer control; a flush in either state clears the queue.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    enq_en  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ib.flush) begin
          state_d = ST_SQUASH;
          clr     = 1'b1;
        end else begin
          enq_en  = 1'b1;
        end
      end
      ST_SQUASH: begin
        clr     = 1'b1;
        state_d = ib.flush ? ST_SQUASH : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  ib_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .enq_en       (enq_en),
    .enq_count    (ib.enq_count),
    .deq_accept   (ib.deq_accept),
    .head         (head),
    .tail         (tail),
    .occupancy    (ib.occupancy),
    .fetch_slots  (ib.fetch_slots),
    .enq_n        (enq_n),
    .overflow_set (overflow_set)
  );

  // Entry storage; not reset so contents survive, only pointers are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IB_LANES; i++) begin
      if (3'(i) < enq_n) mem[tail + PW'(i)] <= ib.enq_entry[i];
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ib.overflow_err <= 1'b0;
    else if (overflow_set) ib.overflow_err <= 1'b1;
  end

  // Oldest four entries from registered storage; no same-cycle bypass.
  always_comb begin
    for (int i = 0; i < IB_LANES; i++) begin
      ib.deq_entry[i] = mem[head + PW'(i)];
      ib.deq_valid[i] = (state_q == ST_RUN) && (OW'(i) < ib.occupancy);
    end
  end

`ifdef IB_PERF_EN
  logic [OW-1:0] sq_add;
  logic [32:0]   sq_sum;

  // Entries thrown away this cycle: queue contents on flush, decode lanes in squash.
  always_comb begin
    sq_add = '0;
    if (state_q == ST_RUN && ib.flush) sq_add = ib.occupancy;
    else if (state_q == ST_SQUASH)     sq_add = OW'(min3(ib.enq_count, 3'(IB_LANES)));
    sq_sum = {1'b0, perf_squashed} + 33'(sq_add);
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_cycles <= '0;
      perf_squashed    <= '0;
    end else begin
      if (ib.occupancy == OW'(DEPTH) && perf_full_cycles != '1)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      perf_squashed <= sq_sum[32] ? '1 : sq_sum[31:0];
    end
  end
`endif

endmodule
